sar_search_ctrl: RTL and testbench

- Sequential binary-search controller that drives the probe operand of an external magnitude comparator and consumes its lt/eq/gt flags to recover an unknown target value.
- The comparator is wired with a = target and b = probe.
- One probe is issued per clock. The block returns the matched value, a found flag and the number of probes used.
- Sits beside the existing comparator block as its driving/consuming end.

---
 rtl/sar_search_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sar_search_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - binary-search controller driving an external magnitude comparator
// Issues one probe per clock and narrows [lo,hi] from the lt/eq/gt flags until a match or an error.
module sar_search_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_alb,
  input  logic             cmp_aeb,
  input  logic             cmp_agb,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probe_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_found;
  logic             r_err;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_probe_count;

  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic             w_found_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [CNT_W-1:0] w_probe_count_nxt;
  logic [WIDTH-1:0] w_probe;
  logic             w_busy;
  logic             w_done;

  // One extra bit on the sum so lo+hi never wraps before halving.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mid;
  logic [WIDTH-1:0] w_mid_dec;
  logic [WIDTH-1:0] w_mid_inc;
  logic             w_onehot;

  assign w_sum     = {1'b0, r_lo} + {1'b0, r_hi};
  assign w_mid     = w_sum[WIDTH:1];
  assign w_mid_dec = w_mid - WIDTH'(1);
  assign w_mid_inc = w_mid + WIDTH'(1);
  assign w_onehot  = ({cmp_alb, cmp_aeb, cmp_agb} == 3'b100) ||
                     ({cmp_alb, cmp_aeb, cmp_agb} == 3'b010) ||
                     ({cmp_alb, cmp_aeb, cmp_agb} == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo          <= '0;
      r_hi          <= '1;
      r_found       <= 1'b0;
      r_err         <= 1'b0;
      r_result      <= '0;
      r_probe_count <= '0;
    end else begin
      r_lo          <= w_lo_nxt;
      r_hi          <= w_hi_nxt;
      r_found       <= w_found_nxt;
      r_err         <= w_err_nxt;
      r_result      <= w_result_nxt;
      r_probe_count <= w_probe_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_lo_nxt          = r_lo;
    w_hi_nxt          = r_hi;
    w_found_nxt       = r_found;
    w_err_nxt         = r_err;
    w_result_nxt      = r_result;
    w_probe_count_nxt = r_probe_count;
    w_probe           = '0;
    w_busy            = 1'b0;
    w_done            = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lo_nxt          = '0;
          w_hi_nxt          = '1;
          w_found_nxt       = 1'b0;
          w_err_nxt         = 1'b0;
          w_result_nxt      = '0;
          w_probe_count_nxt = '0;
          w_state_nxt       = S_SEARCH;
        end
      end

      S_SEARCH: begin
        w_busy            = 1'b1;
        w_probe           = w_mid;
        w_probe_count_nxt = r_probe_count + CNT_W'(1);
        if (!w_onehot) begin
          w_err_nxt   = 1'b1;
          w_found_nxt = 1'b0;
          w_state_nxt = S_DONE;
        end else if (cmp_aeb) begin
          w_result_nxt = w_mid;
          w_found_nxt  = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (cmp_alb) begin
          // Crossed bounds can only come from a comparator that contradicts itself.
          if (w_mid == '0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_hi_nxt = w_mid_dec;
            if (r_lo > w_mid_dec) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end else begin
          if (w_mid == '1) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_lo_nxt = w_mid_inc;
            if (w_mid_inc > r_hi) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign probe       = w_probe;
  assign busy        = w_busy;
  assign done        = w_done;
  assign found       = r_found;
  assign err         = r_err;
  assign result      = r_result;
  assign probe_count = r_probe_count;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - self-checking bench for sar_search_ctrl
// A behavioural comparator feeds the DUT; expected probe sequences come from a plain binary-search model.
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp_alb;
  logic       cmp_aeb;
  logic       cmp_agb;
  logic [7:0] probe;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [7:0] result;
  logic [3:0] probe_count;

  logic [7:0] target;
  int         force_mode;
  int         n_checks;
  int         n_fail;
  int         exp_q[$];

  sar_search_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmp_alb     (cmp_alb),
    .cmp_aeb     (cmp_aeb),
    .cmp_agb     (cmp_agb),
    .probe       (probe),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .err         (err),
    .result      (result),
    .probe_count (probe_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    cmp_alb = 1'b0;
    cmp_aeb = 1'b0;
    cmp_agb = 1'b0;
    case (force_mode)
      0: begin
        cmp_alb = (target < probe);
        cmp_aeb = (target == probe);
        cmp_agb = (target > probe);
      end
      2: begin
        cmp_alb = 1'b1;
        cmp_agb = 1'b1;
      end
      default: ;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void build_model(input int t);
    int lo;
    int hi;
    int mid;
    exp_q.delete();
    lo = 0;
    hi = 255;
    while (lo <= hi) begin
      mid = (lo + hi) / 2;
      exp_q.push_back(mid);
      if (mid == t) break;
      if (t < mid) hi = mid - 1;
      else lo = mid + 1;
    end
  endfunction

  task automatic run_search(input int t, input bit hold);
    build_model(t);
    @(negedge clk);
    target = 8'(t);
    start  = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    foreach (exp_q[i]) begin
      check("busy_search", 32'(busy), 32'(1));
      check("probe_seq", 32'(probe), 32'(exp_q[i]));
      check("done_low", 32'(done), 32'(0));
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'(1));
    check("busy_done", 32'(busy), 32'(0));
    check("probe_done", 32'(probe), 32'(0));
    check("found", 32'(found), 32'(1));
    check("err", 32'(err), 32'(0));
    check("result", 32'(result), 32'(t));
    check("probe_count", 32'(probe_count), 32'(exp_q.size()));
    check("count_bound", 32'(probe_count <= 4'd9), 32'(1));
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_probe", 32'(probe), 32'(0));
  endtask

  task automatic run_bad(input int mode);
    @(negedge clk);
    target     = 8'd50;
    force_mode = mode;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_busy", 32'(busy), 32'(1));
    check("bad_probe", 32'(probe), 32'(127));
    @(negedge clk);
    check("bad_done", 32'(done), 32'(1));
    check("bad_err", 32'(err), 32'(1));
    check("bad_found", 32'(found), 32'(0));
    check("bad_count", 32'(probe_count), 32'(1));
    check("bad_busy_off", 32'(busy), 32'(0));
    force_mode = 0;
    @(negedge clk);
    check("bad_done_off", 32'(done), 32'(0));
    check("bad_err_hold", 32'(err), 32'(1));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    target     = 8'd0;
    force_mode = 0;
    repeat (2) @(negedge clk);
    check("rst_probe", 32'(probe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_found", 32'(found), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_count", 32'(probe_count), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_search(127, 1'b0);
    check("t127_count", 32'(probe_count), 32'(1));
    run_search(0, 1'b0);
    check("t0_count", 32'(probe_count), 32'(8));
    run_search(255, 1'b0);
    check("t255_count", 32'(probe_count), 32'(9));

    run_bad(1);
    run_bad(2);

    for (int t = 0; t < 256; t++) run_search(t, t[0]);
    for (int k = 0; k < 24; k++) run_search(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    target = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_probe", 32'(probe), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_found", 32'(found), 32'(0));
    check("arst_err", 32'(err), 32'(0));
    check("arst_result", 32'(result), 32'(0));
    check("arst_count", 32'(probe_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_probe", 32'(probe), 32'(0));
    check("post_rst_done", 32'(done), 32'(0));
    run_search(200, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
